// File: rtl/branch_predict_ctrl.sv
// Branch/jump resolution unit with a bimodal BHT of 2-bit saturating counters.
// Predicts at fetch, resolves at execute, emits a registered redirect and perf counts.
module branch_predict_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BHT_DEPTH = 16,
    parameter logic [1:0]  CNT_INIT  = 2'b01,
    parameter int unsigned PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_pc,
    input  logic [15:0]       f_instr,
    output logic              f_pred_taken,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [15:0]       ex_instr,
    input  logic [DATA_W-1:0] ex_rs,
    input  logic              ex_pred_taken,
    input  logic              stall,
    output logic              redirect,
    output logic              redirect_taken,
    output logic [PERF_W-1:0] br_count,
    output logic [PERF_W-1:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [1:0] bht_q [BHT_DEPTH];

    logic [4:0]       f_op, ex_op;
    logic [IDX_W-1:0] f_idx, ex_idx;
    logic             ex_cond, ex_jump, ex_cond_taken, actual_taken, resolve, mispredict;

    function automatic logic is_cond(input logic [4:0] op);
        return op[4:2] == 3'b011;
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return (op == 5'b00100) || (op == 5'b00110);
    endfunction

    assign f_op   = f_instr[15:11];
    assign ex_op  = ex_instr[15:11];
    assign f_idx  = f_pc[IDX_W:1];
    assign ex_idx = ex_pc[IDX_W:1];

    // Only the opcode and the index bits of each PC participate.
    logic unused_bits;
    assign unused_bits = ^{f_pc, ex_pc, f_instr[10:0], ex_instr[10:0]};

    assign f_pred_taken = f_valid & (is_jump(f_op) | (is_cond(f_op) & bht_q[f_idx][1]));

    always_comb begin
        ex_cond_taken = 1'b0;
        unique case (ex_op[1:0])
            2'b00: ex_cond_taken = (ex_rs == '0);
            2'b01: ex_cond_taken = (ex_rs != '0);
            2'b10: ex_cond_taken = ex_rs[DATA_W-1];
            2'b11: ex_cond_taken = ~ex_rs[DATA_W-1];
            default: ex_cond_taken = 1'b0;
        endcase
    end

    assign ex_cond      = is_cond(ex_op);
    assign ex_jump      = is_jump(ex_op);
    assign actual_taken = ex_jump | (ex_cond & ex_cond_taken);
    assign resolve      = ex_valid & ~stall;
    assign mispredict   = actual_taken != ex_pred_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= CNT_INIT;
            end
            redirect       <= 1'b0;
            redirect_taken <= 1'b0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            redirect       <= resolve & mispredict;
            redirect_taken <= resolve & mispredict & actual_taken;
            if (resolve && ex_cond) begin
                if (ex_cond_taken && bht_q[ex_idx] != 2'b11) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
                end else if (!ex_cond_taken && bht_q[ex_idx] != 2'b00) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
                end
                if (br_count != '1) begin
                    br_count <= br_count + 1'b1;
                end
                if (mispredict && mispred_count != '1) begin
                    mispred_count <= mispred_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed + randomized bench for branch_predict_ctrl against a behavioural model.
// Two instances share stimulus: default PERF_W and PERF_W=4 for saturation.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid, ex_valid, ex_pred_taken, stall;
    logic [15:0] f_pc, f_instr, ex_pc, ex_instr, ex_rs;
    logic        f_pred_a, f_pred_b, redir_a, redir_b, rt_a, rt_b;
    logic [15:0] br_a, mp_a;
    logic [3:0]  br_b, mp_b;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
        .f_pred_taken(f_pred_a), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs(ex_rs), .ex_pred_taken(ex_pred_taken), .stall(stall), .redirect(redir_a),
        .redirect_taken(rt_a), .br_count(br_a), .mispred_count(mp_a)
    );

    branch_predict_ctrl #(.PERF_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
        .f_pred_taken(f_pred_b), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs(ex_rs), .ex_pred_taken(ex_pred_taken), .stall(stall), .redirect(redir_b),
        .redirect_taken(rt_b), .br_count(br_b), .mispred_count(mp_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: counter value 0..3 per entry, plain integer event counts.
    int bht [16];
    int br16, mp16, br4, mp4;

    localparam logic [15:0] BEQZ = 16'h6000, BNEZ = 16'h6800, BLTZ = 16'h7000;
    localparam logic [15:0] BGEZ = 16'h7800, J = 16'h2000, JAL = 16'h3000, ADD = 16'h0000;

    function automatic int opc(input logic [15:0] i);
        return int'(i) / 2048;
    endfunction

    function automatic bit m_cond(input logic [15:0] i);
        return opc(i) >= 12 && opc(i) <= 15;
    endfunction

    function automatic bit m_jump(input logic [15:0] i);
        return opc(i) == 4 || opc(i) == 6;
    endfunction

    function automatic bit m_taken(input logic [15:0] i, input logic [15:0] rs);
        if (m_jump(i)) return 1'b1;
        case (opc(i))
            12: return rs == 0;
            13: return rs != 0;
            14: return int'(rs) >= 32768;
            15: return int'(rs) < 32768;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_idx(input logic [15:0] pc);
        return (int'(pc) / 2) % 16;
    endfunction

    function automatic bit m_pred(input bit fv, input logic [15:0] pc, input logic [15:0] i);
        return fv && (m_jump(i) || (m_cond(i) && bht[m_idx(pc)] >= 2));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) bht[k] = 1;
        br16 = 0; mp16 = 0; br4 = 0; mp4 = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".br"}, 32'(br_a), 32'(br16));
        chk({tag, ".mp"}, 32'(mp_a), 32'(mp16));
        chk({tag, ".br4"}, 32'(br_b), 32'(br4));
        chk({tag, ".mp4"}, 32'(mp_b), 32'(mp4));
    endtask

    // One cycle: drive both slots, check the fetch prediction, then the resolution.
    task automatic step(input string tag, input bit fv, input logic [15:0] fpc,
                        input logic [15:0] fi, input bit ev, input logic [15:0] epc,
                        input logic [15:0] ei, input logic [15:0] rs, input bit ep,
                        input bit st);
        bit act, res, mis;
        int ix;
        @(negedge clk);
        f_valid = fv; f_pc = fpc; f_instr = fi;
        ex_valid = ev; ex_pc = epc; ex_instr = ei; ex_rs = rs; ex_pred_taken = ep; stall = st;
        #1;
        chk({tag, ".fpred"}, 32'(f_pred_a), 32'(m_pred(fv, fpc, fi)));
        chk({tag, ".fpred4"}, 32'(f_pred_b), 32'(m_pred(fv, fpc, fi)));
        act = m_taken(ei, rs);
        res = ev && !st;
        mis = act != ep;
        if (res && m_cond(ei)) begin
            ix = m_idx(epc);
            bht[ix] = act ? (bht[ix] < 3 ? bht[ix] + 1 : 3) : (bht[ix] > 0 ? bht[ix] - 1 : 0);
            br16 = br16 < 65535 ? br16 + 1 : 65535;
            br4  = br4 < 15 ? br4 + 1 : 15;
            if (mis) begin
                mp16 = mp16 < 65535 ? mp16 + 1 : 65535;
                mp4  = mp4 < 15 ? mp4 + 1 : 15;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".redir"}, 32'(redir_a), 32'(res && mis));
        chk({tag, ".rtaken"}, 32'(rt_a), 32'(res && mis && act));
        chk({tag, ".redir4"}, 32'(redir_b), 32'(res && mis));
        chk_counts(tag);
    endtask

    logic [15:0] ops [8] = '{BEQZ, BNEZ, BLTZ, BGEZ, J, JAL, ADD, 16'h4800};

    function automatic logic [15:0] rnd_instr();
        logic [15:0] r;
        r = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 5) == 0) r = 16'($urandom_range(0, 31)) << 11;
        return r | 16'($urandom_range(0, 2047));
    endfunction

    function automatic logic [15:0] rnd_rs();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        f_valid = 1'b1; f_pc = 16'h0004; f_instr = BEQZ;
        ex_valid = 1'b0; ex_pc = '0; ex_instr = '0; ex_rs = '0; ex_pred_taken = 1'b0; stall = 1'b0;
        model_reset();
        #3;
        chk("reset.redir", 32'(redir_a), 0);
        chk("reset.rtaken", 32'(rt_a), 0);
        chk("reset.fpred", 32'(f_pred_a), 0);
        chk_counts("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Training toward taken, then aliasing lookup at 0x0024.
        step("train1", 1, 16'h0004, BEQZ, 1, 16'h0004, BEQZ, 16'h0000, 0, 0);
        step("train2", 1, 16'h0004, BEQZ, 1, 16'h0004, BEQZ, 16'h0000, 0, 0);
        step("lookup", 1, 16'h0004, BEQZ, 0, 16'h0000, ADD, 16'h0000, 0, 0);
        chk("train.pred_direct", 32'(f_pred_a), 1);
        step("alias", 1, 16'h0024, BNEZ, 0, 16'h0000, ADD, 16'h0000, 0, 0);
        chk("alias.pred_direct", 32'(f_pred_a), 1);

        // Saturation at 00.
        for (int k = 0; k < 3; k++)
            step("sat00", 1, 16'h0010, BEQZ, 1, 16'h0010, BNEZ, 16'h0000, 0, 0);
        chk("sat00.br", 32'(br_a), 5);
        chk("sat00.mp", 32'(mp_a), 2);

        // Same-cycle update and lookup: fetch sees the pre-update counter.
        step("bypass", 1, 16'h0010, BEQZ, 1, 16'h0010, BEQZ, 16'h0000, 0, 0);
        step("bypass2", 1, 16'h0010, BEQZ, 1, 16'h0010, BEQZ, 16'h0000, 0, 0);

        step("jump", 1, 16'h0008, J, 1, 16'h0008, J, 16'h1234, 0, 0);
        step("jal_ok", 1, 16'h0008, JAL, 1, 16'h0008, JAL, 16'h0000, 1, 0);
        step("nonbr", 0, 16'h0008, J, 1, 16'h0008, ADD, 16'h0000, 1, 0);
        step("bltz", 1, 16'h000C, BLTZ, 1, 16'h000C, BLTZ, 16'h8000, 0, 0);
        step("bgez", 1, 16'h000C, BGEZ, 1, 16'h000C, BGEZ, 16'h8000, 1, 0);
        step("stall", 1, 16'h000C, BLTZ, 1, 16'h000C, BLTZ, 16'h8000, 0, 1);
        step("novalid", 1, 16'h000C, BLTZ, 0, 16'h000C, BLTZ, 16'h8000, 0, 0);

        // 17 mispredicting branches saturate the 4-bit counters.
        for (int k = 0; k < 17; k++)
            step("perfsat", 1, 16'h0030, BEQZ, 1, 16'h0030, BEQZ, 16'h0000, 0, 0);
        chk("perfsat.br4", 32'(br_b), 32'h0F);
        chk("perfsat.mp4", 32'(mp_b), 32'h0F);

        // Reset mid-cycle clears a pending redirect and the BHT.
        step("prerst", 1, 16'h0004, BEQZ, 1, 16'h0004, ADD, 16'h0000, 1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.redir", 32'(redir_a), 0);
        chk("midrst.fpred", 32'(f_pred_a), 0);
        chk_counts("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            logic [15:0] ei, epc, fi, fpc;
            ei  = rnd_instr();
            fi  = rnd_instr();
            epc = 16'($urandom) & 16'h007E;
            fpc = 16'($urandom) & 16'h007E;
            step("rand", $urandom_range(0, 3) != 0, fpc, fi, $urandom_range(0, 4) != 0, epc,
                 ei, rnd_rs(), m_pred(1, epc, ei) ^ ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Parametrised branch/jump resolution unit with a bimodal branch history table (BHT) of 2-bit saturating counters, sitting between fetch (prediction) and execute (resolution) of the 16-bit pipelined core. It decodes the same branch/jump opcode set as the existing combinational PC-select logic. It adds per-PC prediction at fetch, registered redirect on mispredict, counter training and saturating performance counters.

## Interface
- DATA_W, 16: width of the rs operand and PC.
- BHT_DEPTH, 16: number of BHT entries, power of 2, 2 to 256; IDX_W = log2(BHT_DEPTH).
- CNT_INIT, 2'b01: reset value of every BHT counter (weakly not-taken).
- PERF_W, 16: width of the performance counters.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_valid  in  1  fetch slot holds a valid instruction.
- f_pc  in  DATA_W  PC of the fetch instruction.
- f_instr  in  16  fetch instruction (predecode only).
- f_pred_taken  out  1  combinational prediction for the fetch slot.
- ex_valid  in  1  execute slot holds a valid instruction.
- ex_pc  in  DATA_W  PC of the execute instruction.
- ex_instr  in  16  execute instruction.
- ex_rs  in  DATA_W  resolved rs operand.
- ex_pred_taken  in  1  prediction carried down the pipe from fetch.
- stall  in  1  freezes EX resolution; no update, no redirect.
- redirect  out  1  registered one-cycle pulse: flush younger instructions and reload the PC.
- redirect_taken  out  1  valid with redirect: 1 = load the branch target, 0 = load ex_pc+2.
- br_count  out  PERF_W  resolved conditional branches, saturating.
- mispred_count  out  PERF_W  mispredicted conditional branches, saturating.

## Operation
- Opcode = instr[15:11].
  - Conditional branches: BEQZ 01100 (rs==0), BNEZ 01101 (rs!=0), BLTZ 01110 (rs[DATA_W-1]==1), BGEZ 01111 (rs[DATA_W-1]==0).
  - Unconditional jumps: J 00100, JAL 00110.
  - Every other opcode is a non-branch.
- BHT index = pc[IDX_W:1] (halfword-aligned PC; bit 0 ignored).
- Fetch prediction (combinational):
  - f_pred_taken = f_valid & (jump | (cond_branch & BHT[idx][1])).
  - Non-branches always predict 0.
- Resolution happens when ex_valid & !stall:
  - actual_taken = 1 for jumps, the condition result for conditional branches, 0 for non-branches.
  - mispredict = actual_taken != ex_pred_taken. This covers jumps that were predicted not-taken and non-branches carrying a stale 1.
- On mispredict, at the next edge: redirect=1 and redirect_taken=actual_taken, for exactly one cycle.
- BHT training, on conditional branches only:
  - Increment if taken, saturating at 11.
  - Decrement if not taken, saturating at 00.
  - Jumps and non-branches never write the BHT.
- Perf counters, on conditional branches only:
  - br_count increments on every resolved conditional branch.
  - mispred_count increments when that branch mispredicts.
  - Both saturate at all-ones.
- stall=1 or ex_valid=0: no BHT write, no counter change, redirect=0 next cycle.

## Timing
- Reset (async assert, synchronous-edge deassert): every BHT entry = CNT_INIT, redirect=0, redirect_taken=0, br_count=0, mispred_count=0.
- Prediction latency 0 cycles (combinational from f_pc/f_instr and BHT state).
- Resolution latency 1 cycle: redirect is asserted in the cycle after the EX inputs are sampled.
- Same-cycle update and lookup of one index: fetch reads the old counter value (no bypass). The new value is visible from the next cycle.
- Back-to-back EX branches: each is resolved independently, and redirect may be high on consecutive cycles. The pipeline is responsible for squashing ex_valid after a redirect.
- Reset asserted mid-operation clears a pending redirect immediately; BHT returns to CNT_INIT.
- Perf counter saturation: at all-ones, further events leave the value unchanged (no wrap).

## Test plan
- Reset: assert rst_n=0 mid-cycle → outputs 0 immediately; fetch BEQZ at any PC gives f_pred_taken=0 (CNT_INIT=01).
- Training: resolve BEQZ at pc=0x0004 with rs=0 twice (ex_pred_taken=0) → redirect=1, redirect_taken=1 each next cycle, BHT[2] 01→10→11; fetch BEQZ at 0x0004 then predicts 1, fetch at 0x0024 (BHT_DEPTH=16, aliases idx 2) also predicts 1.
- Saturation at 00: three not-taken BNEZ (rs=0, ex_pred_taken=0) at pc=0x0010 → no redirect, counter saturates at 00; br_count=3, mispred_count=0.
- Jump and non-branch: J with ex_pred_taken=0 → redirect_taken=1, BHT unchanged, br_count unchanged; ADD (opcode 00000) with ex_pred_taken=1 → redirect=1, redirect_taken=0.
- Sign branches and stall: BLTZ rs=0x8000 taken, BGEZ rs=0x8000 not taken; repeat any mispredicting branch with stall=1 → no redirect, no BHT or counter change.
- Perf saturation: PERF_W=4, 17 mispredicting BEQZ → br_count=mispred_count=4'hF.
